// File: rtl/esm_dwell_sequencer.sv
// Dwell schedule sequencer: walks the dwell table, tunes, opens the dwell window, waits for the stats report.
// Tune and report handshakes stall indefinitely unless ESM_DWELL_SEQ_TIMEOUT_EN enables the watchdog.
package esm_dwell_pkg;
  localparam int esm_dwell_sequence_num_width = 8;
  typedef struct packed {
    logic [15:0] center_freq;
    logic [7:0]  band_cfg;
    logic [15:0] duration_requested;
  } esm_dwell_metadata_t;
endpackage

module esm_dwell_sequencer
  import esm_dwell_pkg::*;
#(
  parameter int NUM_ENTRIES    = 16,
  parameter int SETTLE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 65536,
  localparam int IDX_W = $clog2(NUM_ENTRIES),
  localparam int MD_W  = $bits(esm_dwell_metadata_t),
  localparam int SEQ_W = esm_dwell_sequence_num_width
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Enable,
  input  logic                Cfg_wr_valid,
  input  logic [IDX_W-1:0]    Cfg_wr_index,
  input  logic [MD_W-1:0]     Cfg_wr_data,
  input  logic [IDX_W-1:0]    Cfg_wr_next,
  input  logic                Cfg_wr_last,
  input  logic                Start,
  input  logic [IDX_W-1:0]    Start_index,
  input  logic                Loop,
  input  logic                Stop,
  output logic                Tune_valid,
  output logic [MD_W-1:0]     Tune_data,
  input  logic                Tune_ack,
  output logic                Dwell_active,
  output esm_dwell_metadata_t Dwell_data,
  output logic [SEQ_W-1:0]    Dwell_sequence_num,
  input  logic                Report_ack,
  output logic                Busy,
  output logic                Done,
  output logic                Error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_TUNE   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DWELL  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;

  localparam logic [31:0] SETTLE_LAST  = (SETTLE_CYCLES > 0) ? 32'(SETTLE_CYCLES - 1) : 32'd0;
  localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  esm_dwell_metadata_t tbl_data [NUM_ENTRIES];
  logic [IDX_W-1:0]    tbl_next [NUM_ENTRIES];
  logic                tbl_last [NUM_ENTRIES];

  logic [2:0]          state, nstate;
  logic                busy, done, stop_pend, loop_r, work_last;
  logic [IDX_W-1:0]    idx, start_idx, work_next, tune_idx;
  esm_dwell_metadata_t work;
  logic [31:0]         cnt, dwell_last;
  logic [SEQ_W-1:0]    seq;
  logic                stop_req, load_tune, finish;
`ifdef ESM_DWELL_SEQ_TIMEOUT_EN
  logic                timeout_hit;
`endif

  always_ff @(posedge Clk) begin
    if (Cfg_wr_valid) begin
      tbl_data[Cfg_wr_index] <= Cfg_wr_data;
      tbl_next[Cfg_wr_index] <= Cfg_wr_next;
      tbl_last[Cfg_wr_index] <= Cfg_wr_last;
    end
  end

  assign stop_req   = Stop || !Enable;
  // A zero requested duration still opens the window for one cycle.
  assign dwell_last = (work.duration_requested == 16'd0) ? 32'd0
                    : {16'd0, work.duration_requested - 16'd1};

  always_comb begin
    nstate    = state;
    load_tune = 1'b0;
    tune_idx  = idx;
    finish    = 1'b0;
`ifdef ESM_DWELL_SEQ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      S_IDLE: if (Start && !stop_req) begin
        nstate    = S_TUNE;
        load_tune = 1'b1;
        tune_idx  = Start_index;
      end
      S_TUNE: begin
        if (stop_req) begin
          nstate = S_IDLE;
          finish = 1'b1;
        end else if (Tune_ack) begin
          nstate = (SETTLE_CYCLES == 0) ? S_DWELL : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (stop_req) begin
          nstate = S_IDLE;
          finish = 1'b1;
        end else if (cnt == SETTLE_LAST) begin
          nstate = S_DWELL;
        end
      end
      S_DWELL:  if (cnt == dwell_last) nstate = S_REPORT;
      S_REPORT: if (Report_ack) nstate = S_NEXT;
      S_NEXT: begin
        if (stop_pend || stop_req || (work_last && !loop_r)) begin
          nstate = S_IDLE;
          finish = 1'b1;
        end else begin
          nstate    = S_TUNE;
          load_tune = 1'b1;
          tune_idx  = work_last ? start_idx : work_next;
        end
      end
      default: nstate = S_IDLE;
    endcase
`ifdef ESM_DWELL_SEQ_TIMEOUT_EN
    if ((state == S_TUNE || state == S_REPORT) && nstate == state && cnt == TIMEOUT_LAST) begin
      nstate      = S_IDLE;
      finish      = 1'b1;
      timeout_hit = 1'b1;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      stop_pend <= 1'b0;
      loop_r    <= 1'b0;
      idx       <= '0;
      start_idx <= '0;
      work      <= '0;
      work_next <= '0;
      work_last <= 1'b0;
      cnt       <= '0;
      seq       <= '0;
    end else begin
      state <= nstate;
      busy  <= (nstate != S_IDLE);
      done  <= finish;
      // One counter serves settle, dwell length and the watchdog; every state entry restarts it.
      if (nstate != state)
        cnt <= '0;
      else if (state != S_IDLE)
        cnt <= cnt + 32'd1;
      if (finish || load_tune)
        stop_pend <= 1'b0;
      else if ((state == S_DWELL || state == S_REPORT) && stop_req)
        stop_pend <= 1'b1;
      if (state == S_IDLE && load_tune) begin
        loop_r    <= Loop;
        start_idx <= Start_index;
      end
      if (load_tune) begin
        idx       <= tune_idx;
        work      <= tbl_data[tune_idx];
        work_next <= tbl_next[tune_idx];
        work_last <= tbl_last[tune_idx];
      end
      if (state == S_REPORT && nstate == S_NEXT)
        seq <= seq + 1'b1;
    end
  end

`ifdef ESM_DWELL_SEQ_TIMEOUT_EN
  logic error_r;
  always_ff @(posedge Clk) begin
    if (!Rst_n)
      error_r <= 1'b0;
    else if (timeout_hit)
      error_r <= 1'b1;
  end
  assign Error = error_r;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_LAST;
  assign Error = 1'b0;
`endif

  assign Tune_valid         = (state == S_TUNE);
  assign Tune_data          = (state == S_TUNE) ? work : '0;
  assign Dwell_active       = (state == S_DWELL);
  assign Dwell_data         = (state == S_DWELL) ? work : '0;
  assign Dwell_sequence_num = seq;
  assign Busy               = busy;
  assign Done               = done;

endmodule

// File: tb/tb_esm_dwell_sequencer.sv
// Directed bench for esm_dwell_sequencer; timeout expectations follow ESM_DWELL_SEQ_TIMEOUT_EN.
module tb_esm_dwell_sequencer;
  import esm_dwell_pkg::*;

  localparam int IDX_W = 4;
  localparam int MD_W  = $bits(esm_dwell_metadata_t);

  logic                Clk = 1'b0;
  logic                Rst_n = 1'b0;
  logic                Enable = 1'b1;
  logic                Cfg_wr_valid = 1'b0;
  logic [IDX_W-1:0]    Cfg_wr_index = '0;
  logic [MD_W-1:0]     Cfg_wr_data = '0;
  logic [IDX_W-1:0]    Cfg_wr_next = '0;
  logic                Cfg_wr_last = 1'b0;
  logic                Start = 1'b0;
  logic [IDX_W-1:0]    Start_index = '0;
  logic                Loop = 1'b0;
  logic                Stop = 1'b0;
  logic                Tune_valid;
  logic [MD_W-1:0]     Tune_data;
  logic                Tune_ack = 1'b0;
  logic                Dwell_active;
  esm_dwell_metadata_t Dwell_data;
  logic [7:0]          Dwell_sequence_num;
  logic                Report_ack = 1'b0;
  logic                Busy, Done, Error;

  int checks = 0;
  int failures = 0;

  esm_dwell_sequencer #(.NUM_ENTRIES(16), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable),
    .Cfg_wr_valid(Cfg_wr_valid), .Cfg_wr_index(Cfg_wr_index), .Cfg_wr_data(Cfg_wr_data),
    .Cfg_wr_next(Cfg_wr_next), .Cfg_wr_last(Cfg_wr_last),
    .Start(Start), .Start_index(Start_index), .Loop(Loop), .Stop(Stop),
    .Tune_valid(Tune_valid), .Tune_data(Tune_data), .Tune_ack(Tune_ack),
    .Dwell_active(Dwell_active), .Dwell_data(Dwell_data), .Dwell_sequence_num(Dwell_sequence_num),
    .Report_ack(Report_ack), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic esm_dwell_metadata_t md(input int dur, input int freq, input int band);
    esm_dwell_metadata_t m;
    m.duration_requested = 16'(dur);
    m.center_freq        = 16'(freq);
    m.band_cfg           = 8'(band);
    return m;
  endfunction

  task automatic write_entry(input int index, input esm_dwell_metadata_t m, input int nxt, input bit last);
    Cfg_wr_valid = 1'b1;
    Cfg_wr_index = IDX_W'(index);
    Cfg_wr_data  = m;
    Cfg_wr_next  = IDX_W'(nxt);
    Cfg_wr_last  = last;
    tick();
    Cfg_wr_valid = 1'b0;
  endtask

  // Entered with the DUT in its first TUNE cycle; returns measured phase lengths.
  task automatic do_dwell(input int ack_after, input esm_dwell_metadata_t exp_md, input logic [7:0] exp_seq,
                          input bit stop_mid, input bit give_ack,
                          output int tv, output int st, output int dw, output bit ok);
    tv = 0; st = 0; dw = 0;
    ok = (Tune_data === exp_md);
    while (Tune_valid && tv < 50) begin
      tv++;
      if (tv == ack_after) Tune_ack = 1'b1;
      tick();
      Tune_ack = 1'b0;
    end
    while (Busy && !Dwell_active && st < 100) begin
      st++;
      tick();
    end
    while (Dwell_active && dw < 100) begin
      dw++;
      if (Dwell_data !== exp_md || Dwell_sequence_num !== exp_seq) ok = 1'b0;
      if (stop_mid && dw == 2) Stop = 1'b1;
      tick();
      Stop = 1'b0;
    end
    if (give_ack) begin
      tick();
      tick();
      if (Dwell_active !== 1'b0 || Dwell_data !== '0 || Busy !== 1'b1) ok = 1'b0;
      Report_ack = 1'b1;
      tick();
      Report_ack = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int tv, st, dw, n;
    bit ok;
    int chain_idx [3];
    int chain_dur [3];
    esm_dwell_metadata_t chain_md [3];
    esm_dwell_metadata_t md0, md3, md4;

    // Reset state
    tick(); tick();
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_tune_valid", Tune_valid, 0);
    chk("rst_dwell_active", Dwell_active, 0);
    chk("rst_dwell_data", Dwell_data, 0);
    chk("rst_seq", Dwell_sequence_num, 0);
    chk("rst_error", Error, 0);
    Rst_n = 1'b1;
    tick();

    // Single-entry program: 3-cycle tune, 4 settle, 10-cycle dwell
    md0 = md(10, 16'h1234, 8'h5A);
    write_entry(0, md0, 0, 1'b1);
    Start_index = 4'd0; Loop = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("t1_busy", Busy, 1);
    do_dwell(3, md0, 8'd0, 1'b0, 1'b1, tv, st, dw, ok);
    chk("t1_tune_cycles", tv, 3);
    chk("t1_settle_cycles", st, 4);
    chk("t1_dwell_cycles", dw, 10);
    chk("t1_data", ok, 1);
    chk("t1_seq_after", Dwell_sequence_num, 1);
    chk("t1_done_early", Done, 0);
    tick();
    chk("t1_done", Done, 1);
    chk("t1_busy_low", Busy, 0);
    tick();
    chk("t1_done_pulse", Done, 0);

    // Chain 2 -> 5 -> 7, durations 3/0/8
    chain_idx = '{2, 5, 7};
    chain_dur = '{3, 1, 8};
    chain_md[0] = md(3, 16'h2000, 8'h11);
    chain_md[1] = md(0, 16'h2500, 8'h22);
    chain_md[2] = md(8, 16'h2700, 8'h33);
    write_entry(2, chain_md[0], 5, 1'b0);
    write_entry(5, chain_md[1], 7, 1'b0);
    write_entry(7, chain_md[2], 1, 1'b1);
    Start_index = 4'd2; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_dwell(2, chain_md[i], 8'(1 + i), 1'b0, 1'b1, tv, st, dw, ok);
      chk($sformatf("t2_dwell_len_%0d", chain_idx[i]), dw, chain_dur[i]);
      chk($sformatf("t2_data_%0d", chain_idx[i]), ok, 1);
      tick();
      if (i < 2) chk($sformatf("t2_retune_%0d", i), Tune_valid, 1);
    end
    chk("t2_done", Done, 1);
    chk("t2_seq", Dwell_sequence_num, 4);

    // Looping program 3 -> 4 -> 3, stop during third dwell
    md3 = md(5, 16'h3000, 8'h44);
    md4 = md(4, 16'h4000, 8'h55);
    write_entry(3, md3, 4, 1'b0);
    write_entry(4, md4, 9, 1'b1);
    Start_index = 4'd3; Loop = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0; Loop = 1'b0;
    do_dwell(1, md3, 8'd4, 1'b0, 1'b1, tv, st, dw, ok);
    tick();
    do_dwell(1, md4, 8'd5, 1'b0, 1'b1, tv, st, dw, ok);
    tick();
    chk("t3_loop_back", Tune_data, md3);
    do_dwell(1, md3, 8'd6, 1'b1, 1'b1, tv, st, dw, ok);
    chk("t3_stopped_dwell_len", dw, 5);
    chk("t3_data", ok, 1);
    tick();
    chk("t3_done", Done, 1);
    chk("t3_busy", Busy, 0);
    chk("t3_seq", Dwell_sequence_num, 7);

    // Stop during TUNE, Report_ack while idle, Start+Stop, Start with Enable low
    Start_index = 4'd0; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("t4_in_tune", Tune_valid, 1);
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    chk("t4_abort_busy", Busy, 0);
    chk("t4_abort_done", Done, 1);
    chk("t4_abort_tune", Tune_valid, 0);
    chk("t4_abort_seq", Dwell_sequence_num, 7);
    Report_ack = 1'b1;
    tick();
    Report_ack = 1'b0;
    chk("t4_idle_ack_seq", Dwell_sequence_num, 7);
    Start = 1'b1; Stop = 1'b1;
    tick();
    Start = 1'b0; Stop = 1'b0;
    chk("t4_start_stop_busy", Busy, 0);
    chk("t4_start_stop_done", Done, 0);
    Enable = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0; Enable = 1'b1;
    chk("t4_disabled_busy", Busy, 0);

    // Reset in the middle of a dwell, then a fresh run
    Start_index = 4'd7; Start = 1'b1;
    tick();
    Start = 1'b0; Tune_ack = 1'b1;
    tick();
    Tune_ack = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_in_dwell", Dwell_active, 1);
    tick(); tick();
    Rst_n = 1'b0;
    tick();
    chk("t5_rst_dwell_active", Dwell_active, 0);
    chk("t5_rst_dwell_data", Dwell_data, 0);
    chk("t5_rst_seq", Dwell_sequence_num, 0);
    chk("t5_rst_busy", Busy, 0);
    Rst_n = 1'b1;
    Start_index = 4'd0; Start = 1'b1;
    tick();
    Start = 1'b0;
    do_dwell(2, md0, 8'd0, 1'b0, 1'b1, tv, st, dw, ok);
    chk("t5_rerun_len", dw, 10);
    chk("t5_rerun_data", ok, 1);
    tick();
    chk("t5_rerun_done", Done, 1);
    chk("t5_rerun_seq", Dwell_sequence_num, 1);

    // Report_ack withheld
    Start = 1'b1;
    tick();
    Start = 1'b0;
    do_dwell(1, md0, 8'd1, 1'b0, 1'b0, tv, st, dw, ok);
    chk("t6_dwell_len", dw, 10);
    n = 0;
    while (!Done && n < 300) begin
      tick();
      n++;
    end
`ifdef ESM_DWELL_SEQ_TIMEOUT_EN
    chk("t6_timeout_cycles", n, 100);
    chk("t6_error", Error, 1);
    chk("t6_busy", Busy, 0);
`else
    chk("t6_no_timeout", n, 300);
    chk("t6_error", Error, 0);
    chk("t6_busy", Busy, 1);
`endif
    chk("t6_seq", Dwell_sequence_num, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
